// File: rtl/oam_dma_sink_if.sv
// Bus bundle for oam_dma_sink: DMA beat port, PPU and CPU access ports, status.
// The master modport is the environment side, the slave modport is the sink itself.
interface oam_dma_sink_if;
    logic       dma_run;
    logic       dma_wr;
    logic [7:0] dma_a;
    logic [7:0] dma_d;
    logic       ppu_rd;
    logic [7:0] ppu_a;
    logic [7:0] ppu_dout;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_a;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       busy;
    logic       done;
    logic [7:0] beat_cnt;
    logic       abort_err;
    logic       seq_err;

    modport master (
        output dma_run, dma_wr, dma_a, dma_d, ppu_rd, ppu_a,
               cpu_rd, cpu_wr, cpu_a, cpu_din,
        input  ppu_dout, cpu_dout, busy, done, beat_cnt, abort_err, seq_err
    );

    modport slave (
        input  dma_run, dma_wr, dma_a, dma_d, ppu_rd, ppu_a,
               cpu_rd, cpu_wr, cpu_a, cpu_din,
        output ppu_dout, cpu_dout, busy, done, beat_cnt, abort_err, seq_err
    );
endinterface

// File: rtl/oam_dma_sink.sv
// OAM-side DMA responder: stores DMA beats into OAM and arbitrates DMA > PPU > CPU.
// Optional in-order beat checking is enabled by defining OAM_DMA_SEQ_CHECK_EN.
module oam_dma_sink #(
    parameter int OAM_BYTES = 160
) (
    input  logic              clk1,
    input  logic              reset,
    oam_dma_sink_if.slave     bus
);
    localparam logic [7:0] ADDR_LIMIT = 8'(OAM_BYTES);
    localparam logic [7:0] LAST_CNT   = 8'(OAM_BYTES - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t     state_r, state_next_s;
    logic [7:0] mem_r [0:OAM_BYTES-1];
    logic       hold_r;
    logic [7:0] beat_cnt_r;
    logic       done_r, abort_err_r;
    logic [7:0] ppu_dout_r, cpu_dout_r;
    logic       start_s, abort_s, beat_ok_s, accept_s, finish_s, seq_ok_s, seq_bad_s;
    logic       wr_en_s;
    logic [7:0] wr_addr_s, wr_data_s;

    // State register
    always_ff @(posedge clk1) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Next-state logic; hold_r keeps a finished transfer from restarting until dma_run drops
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   state_next_s = (bus.dma_run && !hold_r) ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_next_s = (!bus.dma_run || finish_s) ? ST_IDLE : ST_ACTIVE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        start_s   = 1'b0;
        abort_s   = 1'b0;
        beat_ok_s = 1'b0;
        accept_s  = 1'b0;
        finish_s  = 1'b0;
        seq_bad_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s = bus.dma_run && !hold_r;
            end
            ST_ACTIVE: begin
                abort_s   = !bus.dma_run;
                beat_ok_s = bus.dma_run && bus.dma_wr && (bus.dma_a < ADDR_LIMIT);
                accept_s  = beat_ok_s && seq_ok_s;
                seq_bad_s = beat_ok_s && !seq_ok_s;
                finish_s  = accept_s && (beat_cnt_r == LAST_CNT);
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Single OAM write port: DMA beats while active, CPU writes only while idle
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = 8'h00;
        wr_data_s = 8'h00;
        if (accept_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = bus.dma_a;
            wr_data_s = bus.dma_d;
        end else if (state_r == ST_IDLE && bus.cpu_wr && bus.cpu_a < ADDR_LIMIT) begin
            wr_en_s   = 1'b1;
            wr_addr_s = bus.cpu_a;
            wr_data_s = bus.cpu_din;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // OAM storage, deliberately not cleared by reset
    always_ff @(posedge clk1) begin
        if (wr_en_s && !reset) mem_r[wr_addr_s] <= wr_data_s;
    end

    // Transfer bookkeeping and sticky abort flag
    always_ff @(posedge clk1) begin
        if (reset) begin
            hold_r      <= 1'b0;
            beat_cnt_r  <= 8'h00;
            done_r      <= 1'b0;
            abort_err_r <= 1'b0;
        end else begin
            done_r <= finish_s;
            if (finish_s)          hold_r <= 1'b1;
            else if (!bus.dma_run) hold_r <= 1'b0;
            if (start_s)           beat_cnt_r <= 8'h00;
            else if (accept_s)     beat_cnt_r <= beat_cnt_r + 8'h01;
            if (start_s)           abort_err_r <= 1'b0;
            else if (abort_s)      abort_err_r <= 1'b1;
        end
    end

`ifdef OAM_DMA_SEQ_CHECK_EN
    logic [7:0] exp_addr_r;
    logic       seq_err_r;

    assign seq_ok_s = (bus.dma_a == exp_addr_r);

    // Expected-address tracking; out-of-order beats are dropped and flagged
    always_ff @(posedge clk1) begin
        if (reset) begin
            exp_addr_r <= 8'h00;
            seq_err_r  <= 1'b0;
        end else begin
            if (start_s)        exp_addr_r <= 8'h00;
            else if (accept_s)  exp_addr_r <= exp_addr_r + 8'h01;
            if (start_s)        seq_err_r <= 1'b0;
            else if (seq_bad_s) seq_err_r <= 1'b1;
        end
    end

    assign bus.seq_err = seq_err_r;
`else
    assign seq_ok_s    = 1'b1;
    assign bus.seq_err = 1'b0;
`endif

    // PPU read port; a same-cycle DMA beat to the same address is forwarded
    always_ff @(posedge clk1) begin
        if (reset) begin
            ppu_dout_r <= 8'h00;
        end else if (bus.ppu_rd) begin
            if (bus.ppu_a >= ADDR_LIMIT)                 ppu_dout_r <= 8'h00;
            else if (accept_s && bus.ppu_a == bus.dma_a) ppu_dout_r <= bus.dma_d;
            else                                         ppu_dout_r <= mem_r[bus.ppu_a];
        end
    end

    // CPU read port; locked out while busy, and a simultaneous write suppresses the read
    always_ff @(posedge clk1) begin
        if (reset) begin
            cpu_dout_r <= 8'h00;
        end else if (bus.cpu_rd && !bus.cpu_wr) begin
            if (state_r == ST_ACTIVE)        cpu_dout_r <= 8'hFF;
            else if (bus.cpu_a >= ADDR_LIMIT) cpu_dout_r <= 8'h00;
            else                             cpu_dout_r <= mem_r[bus.cpu_a];
        end
    end

    assign bus.busy      = (state_r == ST_ACTIVE);
    assign bus.done      = done_r;
    assign bus.beat_cnt  = beat_cnt_r;
    assign bus.abort_err = abort_err_r;
    assign bus.ppu_dout  = ppu_dout_r;
    assign bus.cpu_dout  = cpu_dout_r;
endmodule

// File: tb/tb_oam_dma_sink.sv
// Directed self-checking bench for oam_dma_sink (both OAM_DMA_SEQ_CHECK_EN settings).
module tb_oam_dma_sink;
    logic clk1;
    logic reset;
    int   checks;
    int   errors;
    int   done_cnt;

    oam_dma_sink_if bus ();

    oam_dma_sink #(.OAM_BYTES(160)) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
        if (bus.done === 1'b1) done_cnt++;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %02h expected %02h", tag, obs, exp);
            $error("tag=%s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] d);
        bus.dma_wr = 1'b1;
        bus.dma_a  = a;
        bus.dma_d  = d;
        tick();
        bus.dma_wr = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic cpu_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.cpu_rd = 1'b1;
        bus.cpu_a  = a;
        tick();
        bus.cpu_rd = 1'b0;
        check(tag, bus.cpu_dout, exp);
    endtask

    initial begin
        checks = 0; errors = 0; done_cnt = 0;
        reset = 1'b1;
        bus.dma_run = 1'b0; bus.dma_wr = 1'b0; bus.dma_a = 8'h00; bus.dma_d = 8'h00;
        bus.ppu_rd = 1'b0; bus.ppu_a = 8'h00;
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_a = 8'h00; bus.cpu_din = 8'h00;
        tick();
        tick();
        check("rst_ppu_dout", bus.ppu_dout, 8'h00);
        check("rst_cpu_dout", bus.cpu_dout, 8'h00);
        check("rst_busy", {7'd0, bus.busy}, 8'h00);
        check("rst_done", {7'd0, bus.done}, 8'h00);
        check("rst_beat_cnt", bus.beat_cnt, 8'h00);
        check("rst_abort", {7'd0, bus.abort_err}, 8'h00);
        check("rst_seq", {7'd0, bus.seq_err}, 8'h00);
        reset = 1'b0;
        tick();

        // Idle access and beats ignored while idle
        bus.cpu_wr = 1'b1; bus.cpu_a = 8'h9F; bus.cpu_din = 8'hA5;
        tick();
        bus.cpu_wr = 1'b0;
        cpu_read("idle_rd_9f", 8'h9F, 8'hA5);
        cpu_read("idle_rd_a0", 8'hA0, 8'h00);
        bus.ppu_rd = 1'b1; bus.ppu_a = 8'h9F;
        tick();
        bus.ppu_rd = 1'b0;
        check("idle_ppu_9f", bus.ppu_dout, 8'hA5);
        bus.dma_wr = 1'b1; bus.dma_a = 8'h05; bus.dma_d = 8'hEE;
        tick();
        bus.dma_wr = 1'b0;
        check("idle_beat_ignored", bus.beat_cnt, 8'h00);
        check("idle_not_busy", {7'd0, bus.busy}, 8'h00);

        // Full transfer with CPU lockout and PPU forwarding
        bus.dma_run = 1'b1;
        tick();
        check("start_busy", {7'd0, bus.busy}, 8'h01);
        check("start_cnt", bus.beat_cnt, 8'h00);
        for (int i = 0; i < 159; i++) begin
            if (i == 50) begin
                bus.ppu_rd = 1'b1; bus.ppu_a = 8'd50;
                bus.dma_wr = 1'b1; bus.dma_a = 8'd50; bus.dma_d = 8'h6D;
                tick();
                bus.ppu_rd = 1'b0; bus.dma_wr = 1'b0;
                check("ppu_forward", bus.ppu_dout, 8'h6D);
                tick();
            end else begin
                beat(8'(i), 8'(159 - i));
            end
            if (i == 20) cpu_read("lock_rd", 8'h10, 8'hFF);
            if (i == 40) begin
                bus.cpu_wr = 1'b1; bus.cpu_a = 8'h20; bus.cpu_din = 8'h55;
                tick();
                bus.cpu_wr = 1'b0;
            end
            if (i == 60) begin
                bus.ppu_rd = 1'b1; bus.ppu_a = 8'h00;
                tick();
                bus.ppu_rd = 1'b0;
                check("ppu_busy_rd", bus.ppu_dout, 8'h9F);
            end
            if (i == 99) check("mid_cnt", bus.beat_cnt, 8'd100);
        end
        check("pre_done", {7'd0, bus.done}, 8'h00);
        bus.dma_wr = 1'b1; bus.dma_a = 8'd159; bus.dma_d = 8'h00;
        tick();
        bus.dma_wr = 1'b0;
        check("done_pulse", {7'd0, bus.done}, 8'h01);
        check("done_busy", {7'd0, bus.busy}, 8'h00);
        check("done_cnt160", bus.beat_cnt, 8'd160);
        tick();
        check("done_one_cycle", {7'd0, bus.done}, 8'h00);
        tick();
        tick();
        check("no_restart", {7'd0, bus.busy}, 8'h00);
        check("done_count1", 8'(done_cnt), 8'd1);
        bus.dma_run = 1'b0;
        tick();
        cpu_read("oam0", 8'h00, 8'h9F);
        cpu_read("oam159", 8'd159, 8'h00);
        cpu_read("oam20_dma", 8'h20, 8'h7F);

        // Abort after 50 beats plus an out-of-range beat
        bus.dma_run = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) beat(8'(i), 8'(i + 64));
        beat(8'hA0, 8'hEE);
        check("oor_beat_cnt", bus.beat_cnt, 8'd50);
        bus.dma_run = 1'b0;
        tick();
        check("abort_flag", {7'd0, bus.abort_err}, 8'h01);
        check("abort_busy", {7'd0, bus.busy}, 8'h00);
        check("abort_no_done", 8'(done_cnt), 8'd1);
        cpu_read("abort_oam0", 8'h00, 8'h40);
        cpu_read("abort_oam49", 8'd49, 8'h71);
        cpu_read("abort_oam50", 8'd50, 8'h6D);

        // Sequence check: beats 0, 1, 3
        bus.dma_run = 1'b1;
        tick();
        check("abort_cleared", {7'd0, bus.abort_err}, 8'h00);
        beat(8'h00, 8'h11);
        beat(8'h01, 8'h22);
        beat(8'h03, 8'h33);
`ifdef OAM_DMA_SEQ_CHECK_EN
        check("seq_cnt", bus.beat_cnt, 8'd2);
        check("seq_err", {7'd0, bus.seq_err}, 8'h01);
`else
        check("seq_cnt", bus.beat_cnt, 8'd3);
        check("seq_err", {7'd0, bus.seq_err}, 8'h00);
`endif
        bus.dma_run = 1'b0;
        tick();
`ifdef OAM_DMA_SEQ_CHECK_EN
        cpu_read("seq_oam3", 8'h03, 8'h43);
`else
        cpu_read("seq_oam3", 8'h03, 8'h33);
`endif

        // Mid-transfer reset after 80 beats
        bus.dma_run = 1'b1;
        tick();
        for (int i = 0; i < 80; i++) beat(8'(i), 8'(i + 1));
        check("pre_reset_cnt", bus.beat_cnt, 8'd80);
        bus.ppu_rd = 1'b1; bus.ppu_a = 8'h05;
        tick();
        bus.ppu_rd = 1'b0;
        check("pre_reset_ppu", bus.ppu_dout, 8'h06);
        reset = 1'b1;
        tick();
        check("mrst_ppu_dout", bus.ppu_dout, 8'h00);
        check("mrst_cpu_dout", bus.cpu_dout, 8'h00);
        check("mrst_busy", {7'd0, bus.busy}, 8'h00);
        check("mrst_done", {7'd0, bus.done}, 8'h00);
        check("mrst_cnt", bus.beat_cnt, 8'h00);
        check("mrst_abort", {7'd0, bus.abort_err}, 8'h00);
        check("mrst_seq", {7'd0, bus.seq_err}, 8'h00);
        reset = 1'b0;
        tick();
        check("restart_busy", {7'd0, bus.busy}, 8'h01);
        check("restart_cnt", bus.beat_cnt, 8'h00);
        beat(8'h00, 8'h5A);
        check("restart_cnt1", bus.beat_cnt, 8'h01);
        bus.dma_run = 1'b0;
        tick();
        check("final_done_count", 8'(done_cnt), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/oam_dma_sink.md
# oam_dma_sink

OAM-side responder for OAM DMA transfers: accepts the 160 byte beats issued by the DMA controller, writes them into a 160×8 OAM store, and arbitrates OAM access among the DMA engine, the PPU sprite scanner and the CPU. It sits between the DMA controller's OAM write port and the OAM consumers. It locks the CPU out for the full transfer, tracks beat progress, and reports completion and abort or sequence errors.

## Interface
Parameters:
- OAM_BYTES, 160, number of OAM bytes; valid addresses are 0..OAM_BYTES-1.

Ports:
- clk1  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- dma_run  in  1  transfer active, level from the DMA controller.
- dma_wr  in  1  one-cycle beat strobe; qualified by dma_run.
- dma_a  in  8  beat destination address (low byte of FExx).
- dma_d  in  8  beat data.
- ppu_rd  in  1  PPU read request.
- ppu_a  in  8  PPU read address.
- ppu_dout  out  8  PPU read data, registered.
- cpu_rd  in  1  CPU read request (FE00–FEFF decoded upstream).
- cpu_wr  in  1  CPU write request.
- cpu_a  in  8  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data, registered.
- busy  out  1  high in ACTIVE state.
- done  out  1  one-cycle pulse when a transfer completes.
- beat_cnt  out  8  beats accepted in the current transfer, 0..160.
- abort_err  out  1  sticky; dma_run fell before 160 beats.
- seq_err  out  1  sticky; out-of-order beat (see Configuration).

## Operation
- States: IDLE, ACTIVE. Reset → IDLE.
- IDLE → ACTIVE: dma_run sampled high. beat_cnt is cleared to 0 on entry.
- ACTIVE, dma_wr=1: the beat is accepted. OAM[dma_a] ← dma_d and beat_cnt increments, subject to the sequence check.
- ACTIVE, beat_cnt reaches 160: done pulses for one cycle. The block returns to IDLE, and dma_run must drop before a new transfer can start. Further dma_wr strobes in IDLE are ignored.
- ACTIVE, dma_run low with beat_cnt < 160: abort_err is set and the block returns to IDLE. OAM keeps the bytes already written.
- dma_wr with dma_run low, or with dma_a ≥ 160: the beat is ignored and beat_cnt is unchanged.
- Arbitration: DMA > PPU > CPU.
- While busy, CPU reads return 0xFF and CPU writes are dropped.
- While busy, PPU reads return the DMA data when ppu_a equals the beat address in the same cycle. Otherwise they return OAM contents.
- Out of range addresses (≥ 160): CPU and PPU reads return 0x00, and writes are dropped.
- cpu_rd and cpu_wr together: the write wins and cpu_dout holds its previous value.
- abort_err and seq_err clear only on reset or on the next IDLE → ACTIVE transition.
- OAM contents are not cleared by reset.

## Timing
- Reset values: ppu_dout=0x00, cpu_dout=0x00, busy=0, done=0, beat_cnt=0, abort_err=0, seq_err=0, state IDLE.
- busy rises one cycle after dma_run is first sampled high.
- A beat is written at the clock edge on which dma_wr is sampled. A read of that address issued on the next cycle returns the new data.
- cpu_dout and ppu_dout are valid one cycle after the request and hold until the next request.
- done is asserted on the cycle after the edge on which the 160th beat is accepted. busy falls on that same cycle.
- Reset during ACTIVE: the block is in IDLE next cycle, all flags are cleared, and no done pulse is issued.

## Configuration
- OAM_DMA_SEQ_CHECK_EN defined:
  - An expected-address counter is cleared on entry to ACTIVE.
  - A beat with dma_a ≠ expected is dropped, sets seq_err, and does not increment beat_cnt.
  - A beat with the expected address increments the counter.
- OAM_DMA_SEQ_CHECK_EN undefined:
  - Every in-range beat is written at dma_a and counted.
  - seq_err is tied to 0.

## Test plan
- Full transfer: dma_run=1, then 160 beats with dma_a=0..159 and dma_d=0x9F-dma_a, one every 4 cycles. Required: done pulses once and beat_cnt=160. CPU reads after completion return OAM[0]=0x9F and OAM[159]=0x00.
- CPU lockout: during a transfer, cpu_rd at 0x10 returns 0xFF, and cpu_wr 0x55 at 0x20 is dropped. After done, reading 0x20 returns the DMA value.
- Abort: drop dma_run after 50 beats. Required: abort_err=1, no done pulse, busy=0 next cycle, and OAM[0..49] hold DMA data.
- Sequence error (OAM_DMA_SEQ_CHECK_EN defined): beats at addresses 0, 1, 3. Required: seq_err=1, beat_cnt=2, and OAM[3] unchanged. With the macro undefined: beat_cnt=3, OAM[3] written, seq_err=0.
- Mid-transfer reset: assert reset after 80 beats. Required: all outputs at reset values next cycle. A new dma_run then starts with beat_cnt=0.
- Idle access: cpu_wr 0xA5 at 0x9F, then cpu_rd 0x9F returns 0xA5 one cycle later. cpu_rd at 0xA0 returns 0x00.
